// File: rtl/fsm_arb_pkg.sv
// Shared constants and state encoding for the round-robin FSM arbiter.
package fsm_arb_pkg;

   localparam int unsigned N_REQ_DEFAULT = 9;
   localparam int unsigned IDX_W         = 4;
   localparam int unsigned CNT_W         = 4;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGrant   = 2'd1,
      StRelease = 2'd2
   } arb_state_e;

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Rotating-priority selector: first set request bit at or above ptr, searched cyclically.
module rr_pick
   import fsm_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] index,
   output logic             found
);

   logic [IDX_W:0] w_sum;

   // Walk candidates ptr, ptr+1, ... modulo N_REQ; the first hit wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      w_sum = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         w_sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (w_sum >= (IDX_W + 1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W + 1)'(N_REQ);
         end
         if (!found && req[w_sum[IDX_W-1:0]]) begin
            found = 1'b1;
            index = w_sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter for a shared FSM resource with bounded grant tenure.
module fsm_rr_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEFAULT,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   arb_state_e       r_state, w_state_d;
   logic [N_REQ-1:0] r_grant, w_grant_d;
   logic [IDX_W-1:0] r_idx, w_idx_d;
   logic [IDX_W-1:0] r_ptr, w_ptr_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic             r_timeout, w_timeout_d;

   logic [IDX_W-1:0] w_pick;
   logic             w_found;
   logic             w_at_max;
   logic             w_exit;
   logic [IDX_W-1:0] w_ptr_next;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req   (req),
      .ptr   (r_ptr),
      .index (w_pick),
      .found (w_found)
   );

   assign w_at_max   = (r_cnt == CNT_W'(MAX_HOLD));
   assign w_exit     = done || !req[r_idx] || w_at_max;
   assign w_ptr_next = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

   // Next-state and registered-output decode.
   always_comb begin
      w_state_d   = r_state;
      w_grant_d   = r_grant;
      w_idx_d     = r_idx;
      w_ptr_d     = r_ptr;
      w_cnt_d     = r_cnt;
      w_timeout_d = 1'b0;
      unique case (r_state)
         StIdle, StRelease: begin
            w_grant_d = '0;
            w_idx_d   = '0;
            w_cnt_d   = '0;
            w_state_d = StIdle;
            if (w_found) begin
               w_state_d         = StGrant;
               w_grant_d[w_pick] = 1'b1;
               w_idx_d           = w_pick;
               w_cnt_d           = CNT_W'(1);
            end
         end
         StGrant: begin
            if (w_exit) begin
               w_state_d   = StRelease;
               w_grant_d   = '0;
               w_idx_d     = '0;
               w_cnt_d     = '0;
               w_ptr_d     = w_ptr_next;
               // Only a pure tenure expiry counts; done or a dropped request wins.
               w_timeout_d = w_at_max && !done && req[r_idx];
            end else if (!w_at_max) begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_grant_d = '0;
            w_idx_d   = '0;
            w_cnt_d   = '0;
         end
      endcase
   end

   // State register; reset clears everything without waiting for a clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_grant   <= '0;
         r_idx     <= '0;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_grant   <= w_grant_d;
         r_idx     <= w_idx_d;
         r_ptr     <= w_ptr_d;
         r_cnt     <= w_cnt_d;
         r_timeout <= w_timeout_d;
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = |r_grant;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed self-checking bench for fsm_rr_arbiter (default parameters).
module tb_fsm_rr_arbiter;

   logic       clock;
   logic       reset;
   logic [8:0] req;
   logic       done;
   logic [8:0] grant;
   logic [3:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [8:0] req;
      logic       done;
      logic [8:0] exp_grant;
      logic [3:0] exp_idx;
      logic       exp_valid;
      logic       exp_timeout;
   } vec_t;

   vec_t vecs[14];

   fsm_rr_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: cross the active edge, sample on the falling edge, check invariants.
   task automatic step();
      int ones;
      @(posedge clock);
      @(negedge clock);
      ones = 0;
      for (int i = 0; i < 9; i++) if (grant[i] === 1'b1) ones++;
      check("onehot0", ones <= 1, 1);
      check("valid_vs_grant", grant_valid, grant != 9'h000);
   endtask

   task automatic check_out(input string name, input logic [8:0] g, input logic [3:0] idx,
                            input logic v, input logic to);
      check({name, ".grant"}, grant, g);
      check({name, ".idx"}, grant_idx, idx);
      check({name, ".valid"}, grant_valid, v);
      check({name, ".timeout"}, timeout, to);
   endtask

   // Asynchronous reset pulse, released just after a falling edge.
   task automatic do_reset(input logic [8:0] r);
      #2;
      reset = 1'b0;
      req   = r;
      done  = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{9'h001, 1'b0, 9'h001, 4'd0, 1'b1, 1'b0};
      vecs[1]  = '{9'h001, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[2]  = '{9'h000, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[3]  = '{9'h000, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[4]  = '{9'h100, 1'b0, 9'h100, 4'd8, 1'b1, 1'b0};
      vecs[5]  = '{9'h101, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[6]  = '{9'h101, 1'b0, 9'h001, 4'd0, 1'b1, 1'b0};
      vecs[7]  = '{9'h100, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[8]  = '{9'h006, 1'b0, 9'h002, 4'd1, 1'b1, 1'b0};
      vecs[9]  = '{9'h004, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[10] = '{9'h004, 1'b0, 9'h004, 4'd2, 1'b1, 1'b0};
      vecs[11] = '{9'h0FF, 1'b0, 9'h004, 4'd2, 1'b1, 1'b0};
      vecs[12] = '{9'h000, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0};
      vecs[13] = '{9'h000, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0};

      reset = 1'b0;
      req   = 9'h000;
      done  = 1'b0;
      #12;
      check_out("reset_state", 9'h000, 4'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;

      // Table: one cycle per vector.
      for (int v = 0; v < 14; v++) begin
         req  = vecs[v].req;
         done = vecs[v].done;
         step();
         check_out($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_idx,
                   vecs[v].exp_valid, vecs[v].exp_timeout);
      end

      // Full rotation with done pulsed in each owner's first grant cycle.
      do_reset(9'h1FF);
      for (int k = 0; k <= 9; k++) begin
         step();
         check_out($sformatf("rot%0d", k), 9'(1 << (k % 9)), 4'(k % 9), 1'b1, 1'b0);
         done = 1'b1;
         step();
         done = 1'b0;
         check_out($sformatf("rot_gap%0d", k), 9'h000, 4'd0, 1'b0, 1'b0);
      end

      // Single requester held: tenure expires after MAX_HOLD cycles.
      do_reset(9'h008);
      for (int c = 1; c <= 8; c++) begin
         step();
         check_out($sformatf("hold%0d", c), 9'h008, 4'd3, 1'b1, 1'b0);
      end
      step();
      check_out("hold_timeout", 9'h000, 4'd0, 1'b0, 1'b1);
      step();
      check_out("hold_regrant", 9'h008, 4'd3, 1'b1, 1'b0);

      // done coincides with the 8th grant cycle: normal release.
      for (int c = 2; c <= 8; c++) begin
         step();
         check_out($sformatf("dmax%0d", c), 9'h008, 4'd3, 1'b1, 1'b0);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      check_out("done_at_max", 9'h000, 4'd0, 1'b0, 1'b0);

      // Reset asserted mid-grant clears outputs with no clock edge.
      do_reset(9'h020);
      step();
      check_out("pre_reset_owner5", 9'h020, 4'd5, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_out("async_reset", 9'h000, 4'd0, 1'b0, 1'b0);
      req = 9'h1FF;
      @(negedge clock);
      reset = 1'b1;
      step();
      check_out("post_reset_ptr0", 9'h001, 4'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fsm_rr_arbiter.md
FSM_RR_ARBITER -- requirements
Module: fsm_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 9: number of requesters sharing the FSM resource.
REQ-002 Parameter MAX_HOLD, default 8: maximum grant tenure in cycles, legal range 1..15.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous and active-low.
REQ-005 Port req, input, N_REQ: per-requester request level; bit k is requester k.
REQ-006 Port done, input, 1: current owner finished; sampled only in GRANT.
REQ-007 Port grant, output, N_REQ: one-hot registered grant, all-zero when no owner.
REQ-008 Port grant_idx, output, 4: binary index of the owner; 4'd0 when grant_valid=0.
REQ-009 Port grant_valid, output, 1: high exactly when grant is non-zero.
REQ-010 Port timeout, output, 1: one-cycle pulse when a tenure is ended by MAX_HOLD.

Function
REQ-011 States SHALL be IDLE, GRANT and RELEASE, all held in registers.
REQ-012 IDLE/RELEASE with req!=0 SHALL select the first set req bit at or above pointer ptr, searching cyclically (N_REQ-1 wraps to 0), and enter GRANT next cycle.
REQ-013 Grant latency SHALL be exactly one cycle from the arbitrating edge to grant/grant_idx/grant_valid valid.
REQ-014 IDLE with req==0 SHALL stay IDLE; RELEASE with req==0 SHALL go to IDLE.
REQ-015 On entering GRANT the hold counter SHALL load 1 and increment each further GRANT cycle, saturating at MAX_HOLD.
REQ-016 GRANT SHALL exit to RELEASE when done=1, or req[owner]=0, or counter==MAX_HOLD.
REQ-017 timeout SHALL pulse in the RELEASE cycle only when exit was caused by counter==MAX_HOLD with done=0 and req[owner]=1.
REQ-018 done and counter==MAX_HOLD in the same cycle SHALL be a normal release: timeout stays 0.
REQ-019 On GRANT exit ptr SHALL become owner+1, wrapping N_REQ-1 to 0.
REQ-020 RELEASE SHALL last exactly one cycle with grant=0, giving a fixed one-cycle gap between back-to-back owners.
REQ-021 Request changes from non-owners during GRANT SHALL NOT affect the current grant.
REQ-022 grant SHALL never have more than one bit set; grant_idx SHALL always equal the index of that bit.

Reset
REQ-023 Asserting reset (low) SHALL immediately force state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0 and counter=0, including mid-GRANT.
REQ-024 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-025 Package fsm_arb_pkg SHALL hold the state enumeration, N_REQ default and IDX_W=4 constants.
REQ-026 Rotating-priority selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs index, found).
REQ-027 The block SHALL need no memories and at most about 25 flops at N_REQ=9.

Verification
REQ-028 Release reset, then req=9'h001 -> next edge grant=9'h001, grant_idx=0, grant_valid=1.
REQ-029 req=9'h1FF held, done pulsed one cycle after each grant -> grant_idx sequence 0,1,...,8,0 with one zero-grant cycle between owners.
REQ-030 Only req[3] held, done=0 -> grant_idx=3 for 8 cycles, timeout=1 in the RELEASE cycle, then grant_idx=3 again after the gap.
REQ-031 Owner 8 releases with req=9'h101 -> next grant_idx=0 (pointer wrap), not 8.
REQ-032 done=1 on the 8th grant cycle -> release with timeout=0.
REQ-033 reset pulled low mid-GRANT for owner 5 -> grant=0 without waiting for a clock edge; after release req=9'h1FF -> grant_idx=0.
